// File: rtl/pooling_stream.sv
// Streaming max/average pooling reducer.
// Pairwise lane tree, beat accumulator, saturating average output.
module pooling_stream #(
  parameter int DATA_W    = 9,
  parameter int NUM_IN    = 16,
  parameter int SIGNED    = 0,
  parameter int MAX_BEATS = 4,
  parameter int AVG_SHIFT = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [NUM_IN*DATA_W-1:0] feature_in,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        feature_out,
  output logic                     ovf_err
);

  localparam int L  = $clog2(NUM_IN);
  localparam int H  = NUM_IN / 2;
  localparam int SW = DATA_W + L;
  localparam int BW = $clog2(MAX_BEATS);
  localparam int AW = SW + BW;
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic SGN = (SIGNED != 0);

  function automatic logic gt_d(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    return SGN ? ($signed(a) > $signed(b))
               : (a > b);
  endfunction

  function automatic logic gt_a(
    input logic [AW-1:0] a,
    input logic [AW-1:0] b
  );
    return SGN ? ($signed(a) > $signed(b))
               : (a > b);
  endfunction

  function automatic logic [SW-1:0] ext_s(
    input logic [DATA_W-1:0] x
  );
    logic [SW-1:0] r;
    r = {SW{SGN && x[DATA_W-1]}};
    r[DATA_W-1:0] = x;
    return r;
  endfunction

  function automatic logic [AW-1:0] ext_a(
    input logic [SW-1:0] x
  );
    logic [AW-1:0] r;
    r = {AW{SGN && x[SW-1]}};
    r[SW-1:0] = x;
    return r;
  endfunction

  logic [CW-1:0] cnt_q;
  logic          mode_q;
  logic          first_in;
  logic          force_close;
  logic          eff_last;
  logic          mode_eff;

  // window framing at the pipe entry
  always_comb begin
    first_in    = (cnt_q == '0);
    force_close = in_valid && !in_last
               && (cnt_q == CW'(MAX_BEATS));
    eff_last    = in_last || force_close;
    mode_eff    = first_in ? mode : mode_q;
  end

  // beat counter, window mode and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      ovf_err <= 1'b0;
    end else if (in_valid) begin
      mode_q <= mode_eff;
      cnt_q  <= eff_last ? '0 : cnt_q + 1'b1;
      if (force_close) ovf_err <= 1'b1;
    end
  end

  logic [SW-1:0]     s_d [0:L-1][0:NUM_IN-1];
  logic [DATA_W-1:0] x_d [0:L-1][0:NUM_IN-1];
  logic              v_d [0:L-1];
  logic              l_d [0:L-1];
  logic              f_d [0:L-1];
  logic              m_d [0:L-1];

  logic [SW-1:0]     s_q [1:L][0:H-1];
  logic [DATA_W-1:0] x_q [1:L][0:H-1];
  logic              v_q [1:L];
  logic              l_q [1:L];
  logic              f_q [1:L];
  logic              m_q [1:L];

  // tree level inputs: raw lanes at level 0, registers above
  always_comb begin
    for (int l = 0; l < L; l++) begin
      for (int k = 0; k < NUM_IN; k++) begin
        s_d[l][k] = '0;
        x_d[l][k] = '0;
      end
      v_d[l] = 1'b0;
      l_d[l] = 1'b0;
      f_d[l] = 1'b0;
      m_d[l] = 1'b0;
    end
    for (int k = 0; k < NUM_IN; k++) begin
      x_d[0][k] = feature_in[k*DATA_W +: DATA_W];
      s_d[0][k] = ext_s(x_d[0][k]);
    end
    v_d[0] = in_valid;
    l_d[0] = eff_last;
    f_d[0] = first_in;
    m_d[0] = mode_eff;
    for (int l = 1; l < L; l++) begin
      for (int k = 0; k < H; k++) begin
        s_d[l][k] = s_q[l][k];
        x_d[l][k] = x_q[l][k];
      end
      v_d[l] = v_q[l];
      l_d[l] = l_q[l];
      f_d[l] = f_q[l];
      m_d[l] = m_q[l];
    end
  end

  // registered pairwise tree; even lane wins max ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 1; l <= L; l++) begin
        for (int j = 0; j < H; j++) begin
          s_q[l][j] <= '0;
          x_q[l][j] <= '0;
        end
        v_q[l] <= 1'b0;
        l_q[l] <= 1'b0;
        f_q[l] <= 1'b0;
        m_q[l] <= 1'b0;
      end
    end else begin
      for (int l = 0; l < L; l++) begin
        v_q[l+1] <= v_d[l];
        if (v_d[l]) begin
          l_q[l+1] <= l_d[l];
          f_q[l+1] <= f_d[l];
          m_q[l+1] <= m_d[l];
          for (int j = 0; j < H; j++) begin
            if (j < (NUM_IN >> (l + 1))) begin
              s_q[l+1][j] <= s_d[l][2*j]
                           + s_d[l][2*j+1];
              x_q[l+1][j] <=
                gt_d(x_d[l][2*j+1], x_d[l][2*j])
                ? x_d[l][2*j+1] : x_d[l][2*j];
            end
          end
        end
      end
    end
  end

  logic [AW-1:0] tree_a;
  logic [AW-1:0] acc_q;
  logic          acc_fire;
  logic          acc_mode;

  // tree result widened to accumulator width
  always_comb begin
    tree_a = m_q[L] ? ext_a(s_q[L][0])
                    : ext_a(ext_s(x_q[L][0]));
  end

  // fold beats into the window result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      acc_fire <= 1'b0;
      acc_mode <= 1'b0;
    end else begin
      acc_fire <= v_q[L] && l_q[L];
      if (v_q[L]) begin
        acc_mode <= m_q[L];
        if (f_q[L])
          acc_q <= tree_a;
        else if (m_q[L])
          acc_q <= acc_q + tree_a;
        else if (gt_a(tree_a, acc_q))
          acc_q <= tree_a;
      end
    end
  end

  logic [AW-1:0]     shf;
  logic [DATA_W-1:0] avg_sat;

  // scale the sum and clamp into the lane range
  always_comb begin
    if (SGN)
      shf = $unsigned($signed(acc_q) >>> AVG_SHIFT);
    else
      shf = acc_q >> AVG_SHIFT;
    avg_sat = shf[DATA_W-1:0];
    if (SGN) begin
      if (shf[AW-1:DATA_W-1]
          != {(AW-DATA_W+1){shf[AW-1]}})
        avg_sat = shf[AW-1]
          ? {1'b1, {(DATA_W-1){1'b0}}}
          : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      if (|shf[AW-1:DATA_W])
        avg_sat = '1;
    end
  end

  // result register; holds until the next window closes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      feature_out <= '0;
    end else begin
      out_valid <= acc_fire;
      if (acc_fire)
        feature_out <= acc_mode ? avg_sat
                                : acc_q[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_pooling_stream.sv
// Directed bench for pooling_stream.
// Three builds: unsigned/shift6, signed/shift6, unsigned/shift4.
module tb_pooling_stream;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mode = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [143:0] fin = '0;

  logic       ov0, ov1, ov2;
  logic [8:0] fo0, fo1, fo2;
  logic       oe0, oe1, oe2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct packed {
    int         c;
    logic [8:0] v;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  ev_t q2[$];

  pooling_stream #(
    .DATA_W(9), .NUM_IN(16), .SIGNED(0),
    .MAX_BEATS(4), .AVG_SHIFT(6)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_last(in_last),
    .feature_in(fin), .out_valid(ov0),
    .feature_out(fo0), .ovf_err(oe0)
  );

  pooling_stream #(
    .DATA_W(9), .NUM_IN(16), .SIGNED(1),
    .MAX_BEATS(4), .AVG_SHIFT(6)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_last(in_last),
    .feature_in(fin), .out_valid(ov1),
    .feature_out(fo1), .ovf_err(oe1)
  );

  pooling_stream #(
    .DATA_W(9), .NUM_IN(16), .SIGNED(0),
    .MAX_BEATS(4), .AVG_SHIFT(4)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_last(in_last),
    .feature_in(fin), .out_valid(ov2),
    .feature_out(fo2), .ovf_err(oe2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // log every result pulse with its cycle stamp
  always @(posedge clk) begin
    #2;
    if (ov0 === 1'b1) q0.push_back('{c: cyc, v: fo0});
    if (ov1 === 1'b1) q1.push_back('{c: cyc, v: fo1});
    if (ov2 === 1'b1) q2.push_back('{c: cyc, v: fo2});
  end

  function automatic logic [143:0] fill(input logic [8:0] v);
    logic [143:0] d;
    for (int k = 0; k < 16; k++) d[k*9 +: 9] = v;
    return d;
  endfunction

  task automatic put(input logic lst, input logic md,
                     input logic [143:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_last  = lst;
    mode     = md;
    fin      = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic clrq();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 3;
    if ({ov0, ov1, ov2} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_valid got %b want 000", {ov0, ov1, ov2});
    end
    if ({fo0, fo1, fo2} !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_data got %h %h %h want 0", fo0, fo1, fo2);
    end
    if ({oe0, oe1, oe2} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_ovf got %b want 000", {oe0, oe1, oe2});
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single_max();
    logic [143:0] d;
    int dc;
    int gc;
    logic [8:0] gv;
    clrq();
    for (int k = 0; k < 16; k++) d[k*9 +: 9] = 9'(k * 3);
    put(1'b1, 1'b0, d);
    dc = cyc;
    idle(10);
    gc = q0.size() > 0 ? q0[0].c : -1;
    gv = q0.size() > 0 ? q0[0].v : 'x;
    n_cmp += 4;
    if (q0.size() != 1) begin
      n_bad++;
      $display("FAIL single_count got %0d want 1", q0.size());
    end
    if (gc != dc + 6) begin
      n_bad++;
      $display("FAIL single_latency got %0d want %0d", gc - dc, 6);
    end
    if (gv !== 9'd45) begin
      n_bad++;
      $display("FAIL single_value got %0d want 45", gv);
    end
    gv = q1.size() > 0 ? q1[0].v : 'x;
    if (gv !== 9'd45) begin
      n_bad++;
      $display("FAIL single_value_s got %0d want 45", gv);
    end
  endtask

  task automatic test_multi_max();
    logic [8:0] mx [4];
    logic [143:0] d;
    int dc;
    int gc;
    logic [8:0] gv;
    mx = '{9'd10, 9'd300, 9'd7, 9'd299};
    clrq();
    for (int b = 0; b < 4; b++) begin
      d = fill(9'd2);
      d[((5 * b + 3) % 16)*9 +: 9] = mx[b];
      put(b == 3, 1'b0, d);
      dc = cyc;
      if (b == 1) idle(2);
    end
    idle(10);
    gc = q0.size() > 0 ? q0[0].c : -1;
    gv = q0.size() > 0 ? q0[0].v : 'x;
    n_cmp += 4;
    if (q0.size() != 1) begin
      n_bad++;
      $display("FAIL multi_count got %0d want 1", q0.size());
    end
    if (gc != dc + 6) begin
      n_bad++;
      $display("FAIL multi_latency got %0d want 6", gc - dc);
    end
    if (gv !== 9'd300) begin
      n_bad++;
      $display("FAIL multi_value got %0d want 300", gv);
    end
    gv = q1.size() > 0 ? q1[0].v : 'x;
    if (gv !== 9'd10) begin
      n_bad++;
      $display("FAIL multi_value_s got %0d want 10", gv);
    end
  endtask

  task automatic test_avg();
    logic [8:0] lane [3];
    logic [8:0] e0 [3];
    logic [8:0] e1 [3];
    logic [8:0] e2 [3];
    logic [8:0] g;
    lane = '{9'd100, 9'd511, 9'h1FB};
    e0   = '{9'd100, 9'd511, 9'h1FB};
    e1   = '{9'd100, 9'h1FF, 9'h1FB};
    e2   = '{9'd400, 9'd511, 9'd511};
    for (int c = 0; c < 3; c++) begin
      clrq();
      for (int b = 0; b < 4; b++)
        put(b == 3, 1'b1, fill(lane[c]));
      idle(10);
      n_cmp += 4;
      if (q0.size() != 1) begin
        n_bad++;
        $display("FAIL avg%0d_count got %0d want 1", c, q0.size());
      end
      g = q0.size() > 0 ? q0[0].v : 'x;
      if (g !== e0[c]) begin
        n_bad++;
        $display("FAIL avg%0d_u6 got %h want %h", c, g, e0[c]);
      end
      g = q1.size() > 0 ? q1[0].v : 'x;
      if (g !== e1[c]) begin
        n_bad++;
        $display("FAIL avg%0d_s6 got %h want %h", c, g, e1[c]);
      end
      g = q2.size() > 0 ? q2[0].v : 'x;
      if (g !== e2[c]) begin
        n_bad++;
        $display("FAIL avg%0d_u4 got %h want %h", c, g, e2[c]);
      end
    end
  endtask

  task automatic test_signed_max();
    logic [143:0] d;
    logic [8:0] g;
    clrq();
    d = fill(9'h1F9);
    d[0 +: 9]  = 9'h1FF;
    d[9 +: 9]  = 9'h100;
    d[18 +: 9] = 9'h000;
    d[27 +: 9] = 9'h005;
    put(1'b1, 1'b0, d);
    put(1'b1, 1'b0, fill(9'h1FD));
    idle(10);
    n_cmp += 4;
    g = q1.size() > 0 ? q1[0].v : 'x;
    if (g !== 9'h005) begin
      n_bad++;
      $display("FAIL smax_mix got %h want 005", g);
    end
    g = q0.size() > 0 ? q0[0].v : 'x;
    if (g !== 9'h1FF) begin
      n_bad++;
      $display("FAIL umax_mix got %h want 1ff", g);
    end
    g = q1.size() > 1 ? q1[1].v : 'x;
    if (g !== 9'h1FD) begin
      n_bad++;
      $display("FAIL smax_neg got %h want 1fd", g);
    end
    g = q0.size() > 1 ? q0[1].v : 'x;
    if (g !== 9'h1FD) begin
      n_bad++;
      $display("FAIL umax_neg got %h want 1fd", g);
    end
  endtask

  task automatic test_back_to_back();
    logic [143:0] d;
    int da;
    int gc [3];
    logic [8:0] gv [3];
    int ec [3];
    logic [8:0] ev [3];
    clrq();
    d = fill(9'd1);
    d[7*9 +: 9] = 9'd20;
    put(1'b1, 1'b0, d);
    da = cyc;
    put(1'b1, 1'b1, fill(9'd64));
    put(1'b0, 1'b1, fill(9'd32));
    put(1'b1, 1'b0, fill(9'd32));
    idle(12);
    ec = '{da + 6, da + 7, da + 9};
    ev = '{9'd20, 9'd64, 9'd64};
    n_cmp += 1;
    if (q2.size() != 3) begin
      n_bad++;
      $display("FAIL b2b_count got %0d want 3", q2.size());
    end
    for (int i = 0; i < 3; i++) begin
      gc[i] = q2.size() > i ? q2[i].c : -1;
      gv[i] = q2.size() > i ? q2[i].v : 'x;
      n_cmp += 2;
      if (gc[i] != ec[i]) begin
        n_bad++;
        $display("FAIL b2b_cycle%0d got %0d want %0d", i, gc[i] - da, ec[i] - da);
      end
      if (gv[i] !== ev[i]) begin
        n_bad++;
        $display("FAIL b2b_value%0d got %0d want %0d", i, gv[i], ev[i]);
      end
    end
    gv[0] = q0.size() > 2 ? q0[2].v : 'x;
    n_cmp += 1;
    if (gv[0] !== 9'd16) begin
      n_bad++;
      $display("FAIL b2b_u6_c got %0d want 16", gv[0]);
    end
  endtask

  task automatic test_overflow();
    logic [8:0] mx [5];
    logic [143:0] d;
    int dc;
    int gc;
    logic [8:0] gv;
    mx = '{9'd10, 9'd20, 9'd30, 9'd40, 9'd25};
    clrq();
    for (int b = 0; b < 5; b++) begin
      d = fill(9'd1);
      d[(b + 2)*9 +: 9] = mx[b];
      put(1'b0, 1'b0, d);
      dc = cyc;
      if (b == 4) begin
        n_cmp += 1;
        if (oe0 !== 1'b0) begin
          n_bad++;
          $display("FAIL ovf_early got %b want 0", oe0);
        end
      end
    end
    idle(1);
    n_cmp += 1;
    if (oe0 !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_set got %b want 1", oe0);
    end
    idle(9);
    gc = q0.size() > 0 ? q0[0].c : -1;
    gv = q0.size() > 0 ? q0[0].v : 'x;
    n_cmp += 3;
    if (q0.size() != 1) begin
      n_bad++;
      $display("FAIL ovf_count got %0d want 1", q0.size());
    end
    if (gc != dc + 6) begin
      n_bad++;
      $display("FAIL ovf_latency got %0d want 6", gc - dc);
    end
    if (gv !== 9'd40) begin
      n_bad++;
      $display("FAIL ovf_value got %0d want 40", gv);
    end
    put(1'b1, 1'b0, fill(9'd7));
    idle(10);
    gv = q0.size() > 1 ? q0[1].v : 'x;
    n_cmp += 2;
    if (gv !== 9'd7) begin
      n_bad++;
      $display("FAIL ovf_next got %0d want 7", gv);
    end
    if (oe0 !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sticky got %b want 1", oe0);
    end
  endtask

  task automatic test_reset_mid();
    logic [143:0] d;
    int dc;
    int gc;
    logic [8:0] gv;
    clrq();
    put(1'b0, 1'b1, fill(9'd50));
    put(1'b1, 1'b1, fill(9'd50));
    put(1'b0, 1'b1, fill(9'd50));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    n_cmp += 3;
    if (ov0 !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_valid got %b want 0", ov0);
    end
    if (fo0 !== 9'd0) begin
      n_bad++;
      $display("FAIL rmid_data got %h want 0", fo0);
    end
    if (oe0 !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_ovf got %b want 0", oe0);
    end
    rst_n = 1'b1;
    idle(10);
    n_cmp += 1;
    if (q0.size() != 0) begin
      n_bad++;
      $display("FAIL rmid_no_out got %0d want 0", q0.size());
    end
    for (int k = 0; k < 16; k++) d[k*9 +: 9] = 9'(k * 3);
    put(1'b1, 1'b0, d);
    dc = cyc;
    idle(10);
    gc = q0.size() > 0 ? q0[0].c : -1;
    gv = q0.size() > 0 ? q0[0].v : 'x;
    n_cmp += 2;
    if (gc != dc + 6) begin
      n_bad++;
      $display("FAIL rmid_latency got %0d want 6", gc - dc);
    end
    if (gv !== 9'd45) begin
      n_bad++;
      $display("FAIL rmid_value got %0d want 45", gv);
    end
  endtask

  initial begin
    test_reset();
    test_single_max();
    test_multi_max();
    test_avg();
    test_signed_max();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
